// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring divider with signed fixup and start/busy/done handshake
module iterative_divider #(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED_EN      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0]    count;
   logic [WIDTH:0]   rem;        // partial remainder, one guard bit for the shifted trial
   logic [WIDTH-1:0] acc;        // dividend bits shift out at the top, quotient bits shift in at the bottom
   logic [WIDTH-1:0] dvs;        // divisor magnitude
   logic [WIDTH-1:0] orig;       // original dividend, returned as remainder on divide-by-zero
   logic             neg_q;
   logic             neg_r;
   logic             zero_dvs;

   logic             last_step;
   logic             eff_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_dividend;
   logic [WIDTH-1:0] abs_divisor;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign busy       = (state != S_IDLE);
   assign last_step  = (count == CW'(N - 1));

   // Operand conditioning: magnitudes only when a signed op is requested and supported.
   assign eff_signed   = (SIGNED_EN != 0) && signed_op;
   assign a_neg        = eff_signed && dividend[WIDTH-1];
   assign b_neg        = eff_signed && divisor[WIDTH-1];
   assign abs_dividend = a_neg ? -dividend : dividend;
   assign abs_divisor  = b_neg ? -divisor  : divisor;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: IDLE -> RUN on start, RUN for N cycles, one FIX cycle, back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last_step) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // BITS_PER_CYCLE restoring attempt-subtract steps, MSB of the dividend first.
   always_comb begin
      trial    = '0;
      rem_step = rem;
      acc_step = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         trial    = {rem_step[WIDTH-1:0], acc_step[WIDTH-1]};
         acc_step = {acc_step[WIDTH-2:0], 1'b0};
         if (trial >= {1'b0, dvs}) begin
            rem_step    = trial - {1'b0, dvs};
            acc_step[0] = 1'b1;
         end else begin
            rem_step    = trial;
         end
      end
   end

   // Sign fixup and divide-by-zero override of the magnitude result.
   always_comb begin
      q_fix = acc;
      r_fix = rem[WIDTH-1:0];
      if (zero_dvs) begin
         q_fix = '1;
         r_fix = orig;
      end else begin
         if (neg_q) q_fix = -acc;
         if (neg_r) r_fix = -rem[WIDTH-1:0];
      end
   end

   // Datapath: capture operands on accept, iterate in RUN, publish results with a done pulse in FIX.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count       <= '0;
         rem         <= '0;
         acc         <= '0;
         dvs         <= '0;
         orig        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_dvs    <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc      <= abs_dividend;
                  dvs      <= abs_divisor;
                  orig     <= dividend;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  zero_dvs <= (divisor == '0);
                  rem      <= '0;
                  count    <= '0;
               end
            end
            S_RUN: begin
               rem   <= rem_step;
               acc   <= acc_step;
               count <= count + CW'(1);
            end
            S_FIX: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= zero_dvs;
               done        <= 1'b1;
               count       <= '0;
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider at BITS_PER_CYCLE 1, 2 and 4
module tb_iterative_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start_i    [3];
   logic         signed_i   [3];
   logic [W-1:0] dividend_i [3];
   logic [W-1:0] divisor_i  [3];
   logic         busy_o     [3];
   logic         done_o     [3];
   logic         dz_o       [3];
   logic [W-1:0] q_o        [3];
   logic [W-1:0] r_o        [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   iterative_divider #(.WIDTH(W), .BITS_PER_CYCLE(1), .SIGNED_EN(1)) u_div1 (
      .clk(clk), .reset_n(reset_n), .start(start_i[0]), .signed_op(signed_i[0]),
      .dividend(dividend_i[0]), .divisor(divisor_i[0]), .busy(busy_o[0]), .done(done_o[0]),
      .quotient(q_o[0]), .remainder(r_o[0]), .div_by_zero(dz_o[0]));

   iterative_divider #(.WIDTH(W), .BITS_PER_CYCLE(2), .SIGNED_EN(1)) u_div2 (
      .clk(clk), .reset_n(reset_n), .start(start_i[1]), .signed_op(signed_i[1]),
      .dividend(dividend_i[1]), .divisor(divisor_i[1]), .busy(busy_o[1]), .done(done_o[1]),
      .quotient(q_o[1]), .remainder(r_o[1]), .div_by_zero(dz_o[1]));

   iterative_divider #(.WIDTH(W), .BITS_PER_CYCLE(4), .SIGNED_EN(1)) u_div4 (
      .clk(clk), .reset_n(reset_n), .start(start_i[2]), .signed_op(signed_i[2]),
      .dividend(dividend_i[2]), .divisor(divisor_i[2]), .busy(busy_o[2]), .done(done_o[2]),
      .quotient(q_o[2]), .remainder(r_o[2]), .div_by_zero(dz_o[2]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // Edges from accept to done for instance i: W/bpc + 1.
   function automatic int lat_of(input int i);
      int bpc;
      bpc = (i == 0) ? 1 : (i == 1) ? 2 : 4;
      return W / bpc + 1;
   endfunction

   // Reference arithmetic: plain integer division, truncating toward zero in signed mode.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      int ia;
      int ib;
      dz = (b == '0);
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s) begin
         ia = $signed(a);
         ib = $signed(b);
         q  = W'(ia / ib);
         r  = W'(ia % ib);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Transaction model: one op in flight per instance, done exactly lat_of(i) edges after accept.
   int           cyc = 0;
   bit           inflight [3];
   int           due      [3];
   bit           exp_done [3];
   bit           exp_busy [3];
   logic [W-1:0] pq [3];
   logic [W-1:0] pr [3];
   logic         pdz [3];

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         exp_done[i] = 1'b0;
         if (!reset_n) begin
            inflight[i] = 1'b0;
         end else if (inflight[i]) begin
            if (cyc == due[i]) begin
               inflight[i] = 1'b0;
               exp_done[i] = 1'b1;
            end
         end else if (start_i[i] === 1'b1) begin
            inflight[i] = 1'b1;
            due[i]      = cyc + lat_of(i);
            ref_div(dividend_i[i], divisor_i[i], signed_i[i], pq[i], pr[i], pdz[i]);
         end
         exp_busy[i] = inflight[i];
      end
   end

   // Every-cycle comparison of handshake, and of results whenever done is expected.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d_busy@%0d", i, cyc), {31'd0, busy_o[i]}, {31'd0, exp_busy[i]});
         check($sformatf("u%0d_done@%0d", i, cyc), {31'd0, done_o[i]}, {31'd0, exp_done[i]});
         if (exp_done[i]) begin
            check($sformatf("u%0d_quotient@%0d", i, cyc), {16'd0, q_o[i]}, {16'd0, pq[i]});
            check($sformatf("u%0d_remainder@%0d", i, cyc), {16'd0, r_o[i]}, {16'd0, pr[i]});
            check($sformatf("u%0d_div_by_zero@%0d", i, cyc), {31'd0, dz_o[i]}, {31'd0, pdz[i]});
         end
      end
   end

   task automatic check_zero(input string tag, input int i);
      check({tag, "_busy"},      {31'd0, busy_o[i]}, 32'd0);
      check({tag, "_done"},      {31'd0, done_o[i]}, 32'd0);
      check({tag, "_quotient"},  {16'd0, q_o[i]},    32'd0);
      check({tag, "_remainder"}, {16'd0, r_o[i]},    32'd0);
      check({tag, "_dbz"},       {31'd0, dz_o[i]},   32'd0);
   endtask

   // One directed op with literal expectations; optional back-to-back start and a start glitch at edge 'glitch'.
   task automatic do_op(input string tag, input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] xq, input logic [W-1:0] xr, input logic xdz,
                        input int xlat, input bit b2b, input int glitch, output int busy_cnt);
      int lat;
      if (!b2b) @(negedge clk);
      dividend_i[i] = a;
      divisor_i[i]  = b;
      signed_i[i]   = s;
      start_i[i]    = 1'b1;
      @(negedge clk);
      start_i[i]    = 1'b0;
      dividend_i[i] = W'($urandom);
      divisor_i[i]  = W'($urandom);
      busy_cnt      = busy_o[i] ? 1 : 0;
      lat           = 0;
      for (int k = 1; k <= xlat + 8; k++) begin
         if (glitch > 0 && k == glitch) begin
            dividend_i[i] = 16'd9;
            divisor_i[i]  = 16'd3;
            start_i[i]    = 1'b1;
         end
         if (glitch > 0 && k == glitch + 1) start_i[i] = 1'b0;
         @(negedge clk);
         if (done_o[i]) begin
            lat = k;
            break;
         end
         if (busy_o[i]) busy_cnt++;
      end
      start_i[i] = 1'b0;
      check({tag, "_latency"},   lat, xlat);
      check({tag, "_quotient"},  {16'd0, q_o[i]},  {16'd0, xq});
      check({tag, "_remainder"}, {16'd0, r_o[i]},  {16'd0, xr});
      check({tag, "_dbz"},       {31'd0, dz_o[i]}, {31'd0, xdz});
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return W'($urandom_range(1, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // Random ops on one instance; results are judged by the every-cycle compare against the model.
   task automatic rand_driver(input int i, input int nops);
      bit b2b;
      bit seen;
      b2b = 1'b0;
      for (int n = 0; n < nops; n++) begin
         if (!b2b) @(negedge clk);
         dividend_i[i] = rand_operand();
         divisor_i[i]  = rand_operand();
         signed_i[i]   = 1'($urandom_range(0, 1));
         start_i[i]    = 1'b1;
         @(negedge clk);
         start_i[i]    = 1'b0;
         seen          = 1'b0;
         for (int k = 1; k <= lat_of(i) + 4; k++) begin
            @(negedge clk);
            if (done_o[i]) begin
               seen = 1'b1;
               break;
            end
            start_i[i]    = ($urandom_range(0, 7) == 0);
            dividend_i[i] = W'($urandom);
            divisor_i[i]  = W'($urandom);
         end
         start_i[i] = 1'b0;
         check($sformatf("rand_u%0d_done_seen_op%0d", i, n), {31'd0, seen}, 32'd1);
         b2b = 1'($urandom_range(0, 1));
      end
   endtask

   logic [W-1:0] mq;
   logic [W-1:0] mr;
   logic         mdz;
   int           bc;
   bit           saw_done;

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_i[i]    = 1'b0;
         signed_i[i]   = 1'b0;
         dividend_i[i] = '0;
         divisor_i[i]  = '0;
      end

      // Pin the reference arithmetic to hand-computed values.
      ref_div(16'd100, 16'd7, 1'b0, mq, mr, mdz);
      check("model_100_7_q", {16'd0, mq}, 32'h000E);
      check("model_100_7_r", {16'd0, mr}, 32'h0002);
      ref_div(16'hFFF9, 16'h0002, 1'b1, mq, mr, mdz);
      check("model_m7_2_q", {16'd0, mq}, 32'hFFFD);
      check("model_m7_2_r", {16'd0, mr}, 32'hFFFF);
      ref_div(16'h0007, 16'hFFFE, 1'b1, mq, mr, mdz);
      check("model_7_m2_q", {16'd0, mq}, 32'hFFFD);
      check("model_7_m2_r", {16'd0, mr}, 32'h0001);
      ref_div(16'd1234, 16'd0, 1'b0, mq, mr, mdz);
      check("model_dbz_q", {16'd0, mq}, 32'hFFFF);
      check("model_dbz_r", {16'd0, mr}, 32'h04D2);
      check("model_dbz_flag", {31'd0, mdz}, 32'd1);
      ref_div(16'h8000, 16'hFFFF, 1'b1, mq, mr, mdz);
      check("model_ovf_q", {16'd0, mq}, 32'h8000);
      check("model_ovf_r", {16'd0, mr}, 32'h0000);

      repeat (3) @(negedge clk);
      check_zero("reset_state", 0);
      reset_n = 1'b1;

      do_op("t1_100_7", 0, 16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b0, 17, 1'b0, 0, bc);
      check("t1_busy_cycles", bc, 17);
      do_op("t2_m7_2", 0, 16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b0, 0, bc);
      do_op("t2_7_m2", 0, 16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17, 1'b0, 0, bc);
      do_op("t3_dbz", 0, 16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'h04D2, 1'b1, 17, 1'b0, 0, bc);
      do_op("t4_ovf_s", 0, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17, 1'b0, 0, bc);
      do_op("t4_8000_u", 0, 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 17, 1'b0, 0, bc);
      do_op("t4_ffff_1", 0, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17, 1'b0, 0, bc);
      do_op("t5_glitch", 0, 16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b0, 17, 1'b0, 5, bc);
      do_op("t5_first", 0, 16'd200, 16'd9, 1'b0, 16'd22, 16'd2, 1'b0, 17, 1'b0, 0, bc);
      do_op("t5_b2b", 0, 16'hFF38, 16'd9, 1'b1, 16'hFFEA, 16'hFFFE, 1'b0, 17, 1'b1, 0, bc);
      do_op("t6_bpc4", 2, 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 5, 1'b0, 0, bc);
      do_op("t6_bpc2", 1, 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 9, 1'b0, 0, bc);

      // Reset at E8 of an op: abort, no done, outputs cleared.
      @(negedge clk);
      dividend_i[0] = 16'd100;
      divisor_i[0]  = 16'd7;
      signed_i[0]   = 1'b0;
      start_i[0]    = 1'b1;
      @(negedge clk);
      start_i[0]    = 1'b0;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_zero("t5_reset", 0);
      reset_n  = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done_o[0]) saw_done = 1'b1;
      end
      check("t5_reset_no_done", {31'd0, saw_done}, 32'd0);

      fork
         rand_driver(0, 1500);
         rand_driver(1, 2500);
         rand_driver(2, 4000);
      join

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
